// File: rtl/bram_stream_reader.sv
// Streams a burst of BRAM words out on a valid/ready port through a 4-entry FIFO.
// Latency: first beat 3 cycles after start; backpressure via credit = FIFO count + in-flight reads.
module bram_stream_reader #(
    parameter int DW    = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          len,
    output logic                 busy,
    output logic                 done,
    output logic                 b_en,
    output logic [AW-1:0]        b_addr,
    input  logic signed [DW-1:0] b_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    output logic                 m_last
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] ADDR_ONE  = 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t                state, state_nxt;
    logic [AW:0]           rd_left, len_r, beat_cnt;
    logic                  cap;
    logic signed [DW-1:0]  fifo_mem [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            count, credit_use;
    logic                  issue, accept, done_nxt, push, pop;

    assign push       = cap;
    assign m_valid    = (count != 3'd0);
    assign pop        = m_valid && m_ready;
    assign m_data     = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last     = m_valid && (beat_cnt == len_r - CNT_ONE);
    assign busy       = (state != IDLE);
    // Reads in the BRAM pipeline (b_en cycle and capture cycle) hold FIFO slots too.
    assign credit_use = count + {2'b00, b_en} + {2'b00, cap};

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                issue = (rd_left != '0) && (credit_use < 3'd4);
                if ((rd_left == '0) || (issue && rd_left == CNT_ONE))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            b_en     <= 1'b0;
            b_addr   <= '0;
            rd_left  <= '0;
            len_r    <= '0;
            beat_cnt <= '0;
            cap      <= 1'b0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            cap   <= b_en;
            if (accept) begin
                b_en     <= 1'b1;
                b_addr   <= base_addr;
                rd_left  <= len - CNT_ONE;
                len_r    <= len;
                beat_cnt <= '0;
            end else begin
                b_en <= issue;
                if (issue) begin
                    b_addr  <= (b_addr == ADDR_LAST) ? '0 : b_addr + ADDR_ONE;
                    rd_left <= rd_left - CNT_ONE;
                end
            end
            if (push) begin
                fifo_mem[wr_ptr] <= b_dout;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 2'd1;
                beat_cnt <= beat_cnt + CNT_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader against a 16-word BRAM holding mem[i]=i.
module tb_bram_stream_reader;
    localparam int DW = 16, DEPTH = 16, AW = 4;

    logic                 clk = 1'b0;
    logic                 rst, start, busy, done, b_en, m_valid, m_ready, m_last;
    logic [AW-1:0]        base_addr, b_addr;
    logic [AW:0]          len;
    logic signed [DW-1:0] b_dout, m_data;

    bram_stream_reader #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DW-1:0] mem [DEPTH];
    initial begin
        b_dout = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    end
    always @(posedge clk) if (b_en) b_dout <= mem[b_addr];

    int checks = 0, errors = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int rdy_mode = 0, rdy_idx = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) m_ready = 1'b1;
        else begin
            m_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
            rdy_idx++;
        end
    end

    int  exp_dat[$], exp_addr[$];
    bit  exp_last[$];
    int  beat_cycs[$], ben_cycs[$];
    int  issued = 0, taken = 0, max_out = 0, done_cnt = 0, done_cyc = 0, first_valid_cyc = 0;
    bit  valid_seen = 0, stall_prev = 0;
    logic signed [DW-1:0] prev_data;
    logic prev_last;

    always @(negedge clk) begin
        if (rst) stall_prev = 0;
        else begin
            if (b_en) begin
                issued++;
                ben_cycs.push_back(cyc);
                if (exp_addr.size() == 0) chk("spurious_b_en", 1, 0);
                else chk("b_addr", int'(b_addr), exp_addr.pop_front());
            end
            if (stall_prev) begin
                chk("stall_valid", int'(m_valid), 1);
                chk("stall_data", int'(m_data), int'(prev_data));
                chk("stall_last", int'(m_last), int'(prev_last));
            end
            if (m_valid && !valid_seen) begin
                valid_seen = 1;
                first_valid_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                taken++;
                beat_cycs.push_back(cyc);
                if (exp_dat.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    chk("m_data", int'(m_data), exp_dat.pop_front());
                    chk("m_last", int'(m_last), int'(exp_last.pop_front()));
                end
            end
            if (issued - taken > max_out) max_out = issued - taken;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy", int'(busy), 0);
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    int s_cyc;
    task automatic expect_burst(input int b, input int l);
        for (int k = 0; k < l; k++) begin
            exp_addr.push_back((b + k) % DEPTH);
            exp_dat.push_back((b + k) % DEPTH);
            exp_last.push_back(k == l - 1);
        end
    endtask

    task automatic go(input int b, input int l);
        @(posedge clk); #1;
        base_addr = AW'(b); len = (AW+1)'(l); start = 1'b1; s_cyc = cyc;
        expect_burst(b, l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > n0) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_b_en"}, int'(b_en), 0);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_m_last"}, int'(m_last), 0);
        chk({tag, "_b_addr"}, int'(b_addr), 0);
        chk({tag, "_m_data"}, int'(m_data), 0);
    endtask

    task automatic clear_sb();
        exp_dat.delete(); exp_addr.delete(); exp_last.delete();
        beat_cycs.delete(); ben_cycs.delete();
        valid_seen = 0;
    endtask

    int d1, n_ben;
    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) check_idle("reset");
        @(posedge clk); #1 rst = 1'b0;

        // base 10, len 5, always ready: back-to-back beats, done at len+3
        clear_sb();
        go(10, 5);
        wait_done(60);
        chk("first_valid_lat", first_valid_cyc - s_cyc, 3);
        chk("beats_5", beat_cycs.size(), 5);
        if (beat_cycs.size() == 5) chk("beat_span", beat_cycs[4] - beat_cycs[0], 4);
        chk("done_lat", done_cyc - s_cyc, 8);
        chk("sb_empty_1", exp_dat.size(), 0);

        // address wrap past DEPTH-1
        clear_sb();
        go(14, 4);
        wait_done(60);
        chk("wrap_addr_left", exp_addr.size(), 0);
        chk("wrap_dat_left", exp_dat.size(), 0);

        // ready pattern 1,0,0,1 with a credit watch
        clear_sb();
        max_out = 0; rdy_idx = 0; rdy_mode = 1;
        go(3, 8);
        wait_done(200);
        rdy_mode = 0;
        chk("stall_beats", beat_cycs.size(), 8);
        chk("credit_max", int'(max_out <= 4), 1);
        chk("sb_empty_3", exp_dat.size(), 0);

        // len 0: no reads, done next cycle, never busy
        clear_sb();
        n_ben = issued;
        go(5, 0);
        @(negedge clk) chk("len0_busy", int'(busy), 0);
        wait_done(10);
        chk("len0_done_lat", done_cyc - s_cyc, 1);
        repeat (3) @(posedge clk);
        chk("len0_no_b_en", issued - n_ben, 0);

        // reset in the middle of a len 10 burst
        clear_sb();
        go(0, 10);
        for (int i = 0; i < 100 && beat_cycs.size() < 3; i++) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk) check_idle("midrst");
        clear_sb();
        issued = 0; taken = 0;
        @(posedge clk); #1 rst = 1'b0;
        go(0, 2);
        wait_done(60);
        chk("post_rst_beats", beat_cycs.size(), 2);
        chk("sb_empty_6", exp_dat.size(), 0);

        // start held high: second burst begins only at the done cycle
        clear_sb();
        @(posedge clk); #1;
        base_addr = AW'(4); len = (AW+1)'(3); start = 1'b1; s_cyc = cyc;
        expect_burst(4, 3);
        expect_burst(4, 3);
        wait_done(60);
        d1 = done_cyc;
        chk("held_done1_lat", d1 - s_cyc, 6);
        #1 start = 1'b0;
        wait_done(60);
        chk("held_done2_lat", done_cyc - d1, 6);
        chk("held_b_en_total", ben_cycs.size(), 6);
        if (ben_cycs.size() == 6) chk("held_restart_cyc", ben_cycs[3], d1 + 1);
        chk("held_beats", beat_cycs.size(), 6);
        chk("sb_empty_7", exp_dat.size(), 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DW, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 1024, words in the attached BRAM.
REQ-003 SHALL have parameter AW, default (DEPTH<=1 ? 1 : $clog2(DEPTH)), address width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  AW  first word address; sampled with start.
REQ-008 SHALL have port len  input  AW+1  word count, 0..DEPTH; sampled with start.
REQ-009 SHALL have port busy  output  1  burst in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-011 SHALL have port b_en  output  1  BRAM read-port enable.
REQ-012 SHALL have port b_addr  output  AW  BRAM read address.
REQ-013 SHALL have port b_dout  input  DW signed  BRAM read data, valid the cycle after b_en.
REQ-014 SHALL have port m_valid  output  1  stream beat valid.
REQ-015 SHALL have port m_ready  input  1  downstream accept.
REQ-016 SHALL have port m_data  output  DW signed  stream beat data.
REQ-017 SHALL have port m_last  output  1  marks final beat of the burst.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN; busy=1 in RUN and DRAIN only.
REQ-019 IDLE->RUN at the edge where start=1 and len!=0; start while busy SHALL be ignored.
REQ-020 start with len=0 SHALL issue no reads, stay IDLE, pulse done in the next cycle.
REQ-021 b_en/b_addr SHALL be registered; first read (b_addr=base_addr) SHALL appear the cycle after the start edge.
REQ-022 Read k SHALL use address (base_addr+k) mod DEPTH; wrap past DEPTH-1 to 0.
REQ-023 b_dout SHALL be captured into a 4-entry FIFO exactly one cycle after each b_en=1 cycle.
REQ-024 A read SHALL be issued only while reads remain and FIFO count + in-flight reads < 4 (in-flight max 2).
REQ-025 With m_ready held 1, SHALL sustain one beat per cycle; first m_valid 3 cycles after start edge.
REQ-026 m_valid = FIFO non-empty; m_data = FIFO head; beat transfers when m_valid&&m_ready.
REQ-027 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 Simultaneous FIFO push and pop SHALL keep count unchanged; no overflow or underflow under any m_ready pattern.
REQ-029 m_last=1 exactly on beat len-1 (zero-based).
REQ-030 RUN->DRAIN when final read issued; DRAIN->IDLE at the edge transferring the m_last beat.
REQ-031 done SHALL pulse 1 cycle, the cycle after the m_last transfer; busy=0 in that cycle.
REQ-032 A start asserted during the done cycle SHALL be accepted.
REQ-033 Beats SHALL be emitted in address order with no loss or duplication.

Reset
REQ-034 rst SHALL force IDLE; busy, done, b_en, m_valid, m_last=0; b_addr, m_data=0; FIFO empty; in-flight count 0.
REQ-035 rst mid-burst SHALL discard in-flight and buffered data; a later start SHALL behave as from fresh reset.
REQ-036 rst SHALL take priority over start in the same cycle.

Verification
REQ-037 BRAM mem[i]=i; start base=10 len=5, m_ready=1 -> m_data 10..14 on consecutive cycles, m_last on 14, done next cycle.
REQ-038 DEPTH=16, base=14, len=4 -> b_addr 14,15,0,1; data mem[14],mem[15],mem[0],mem[1].
REQ-039 len=8, m_ready toggling 1,0,0,1 pattern -> all 8 beats in order, data stable while stalled, b_en never exceeds credit.
REQ-040 start with len=0 -> no b_en, done pulse next cycle, busy stays 0.
REQ-041 rst asserted on beat 3 of len=10 -> outputs zero next cycle; new start base=0 len=2 -> exactly 2 beats, m_last on second.
REQ-042 start held high through a burst -> second burst starts only at the done cycle; no overlap of beats.
